div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of divide-ratio field and half-period counter.
REQ-002 Parameter BURST_W, default 16, width of burst-length field and remaining-edge counter.
REQ-003 Parameter DIV_RST, default 3, divide ratio loaded at reset.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cfg_valid  input  1  new configuration offered.
REQ-007 cfg_ready  output  1  configuration slot free; transfer occurs when cfg_valid && cfg_ready.
REQ-008 cfg_div  input  CNT_W  half-period minus one, in clk_in cycles.
REQ-009 cfg_burst  input  BURST_W  rising edges per burst; 0 = continuous.
REQ-010 start  input  1  single-cycle run request.
REQ-011 stop  input  1  single-cycle halt request.
REQ-012 clk_div  output  1  registered divided clock.
REQ-013 tick  output  1  one-cycle pulse, asserted in the same cycle clk_div first reads 1 after a 0->1 toggle.
REQ-014 busy  output  1  high in RUN and DRAIN.
REQ-015 done  output  1  one-cycle pulse on burst completion.

Function
REQ-016 States SHALL be IDLE, RUN, DRAIN.
REQ-017 In RUN/DRAIN, half-period counter SHALL count 0..div_act; at cnt>=div_act it SHALL toggle clk_div and clear cnt, otherwise increment; half-period = div_act+1 cycles.
REQ-018 cfg_div=0 SHALL give clk_div = clk_in/2 (toggle every cycle).
REQ-019 An accepted config SHALL be held in a pending register; cfg_ready SHALL be low while pending is occupied.
REQ-020 In IDLE, pending SHALL be copied to div_act/burst_act the cycle after acceptance.
REQ-021 In RUN/DRAIN, pending SHALL be applied only in the cycle of a 1->0 toggle; new ratio governs the following low half; no partial periods.
REQ-022 Acceptance and apply in the same cycle: the held value is applied; the new one enters pending.
REQ-023 IDLE + start: cnt<=0, clk_div stays 0, remaining<=burst_act, go RUN; first tick div_act+1 cycles after start.
REQ-024 Each 0->1 toggle: tick=1; if burst_act!=0, remaining decrements.
REQ-025 Burst mode: 1->0 toggle with remaining==0 -> IDLE, done=1 that cycle; clk_div ends at 0.
REQ-026 RUN + stop: clk_div==0 -> IDLE next cycle; clk_div==1 -> DRAIN, finish high half, fall, then IDLE; done not asserted.
REQ-027 start and stop in the same cycle: stop wins (from IDLE: no action).
REQ-028 start in RUN/DRAIN and stop in IDLE SHALL be ignored.
REQ-029 Mid-run burst_act change SHALL NOT alter remaining; it takes effect at the next start.
REQ-030 clk_div SHALL never produce a high or low phase shorter than div_act+1 cycles of the ratio in force at that phase's start.

Reset
REQ-031 On rst_n low: state=IDLE, clk_div=0, tick=0, done=0, busy=0, cfg_ready=1, pending empty, cnt=0, remaining=0, div_act=DIV_RST, burst_act=0.
REQ-032 Reset mid-run SHALL force clk_div low immediately; any pending config is discarded.

Structure
REQ-033 Package div_ctrl_pkg SHALL hold the state encoding and the CNT_W/BURST_W/DIV_RST defaults.
REQ-034 Half-period counter and toggle register SHALL be sub-module div_core (inputs: enable, ratio; outputs: clk_div, rise, fall pulses).

Verification
REQ-035 Reset, cfg_div=3, burst=0, start -> first tick 4 cycles after start; period 8 cycles; busy=1.
REQ-036 cfg_div=1, burst=3, start -> exactly 3 ticks, done 1 cycle on third fall, clk_div=0, busy=0.
REQ-037 Running div=2; at mid-high phase offer cfg_div=5 -> cfg_ready low until next fall; then low phase 6 cycles, high 6.
REQ-038 Running div=4; stop while clk_div=1 -> high phase completes (5 cycles total), then IDLE, no done; stop while clk_div=0 -> IDLE next cycle.
REQ-039 start+stop same cycle in IDLE -> stays IDLE; start during RUN -> no change to counters.
REQ-040 rst_n low mid-high phase -> clk_div=0 asynchronously; after release, div_act=3, cfg_ready=1.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared definitions for the programmable clock divider.
//   - Default parameter values for divide-ratio width, burst width and the
//     divide ratio loaded at reset.
//   - Controller state encoding.
package div_ctrl_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int BURST_W_DEF = 16;
    localparam int DIV_RST_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/div_core.sv
// div_core: half-period counter plus the clk_div toggle register.
// Ports:
//   clk_in, rst_n  clock / asynchronous active-low reset
//   en_i           count enable (controller is in RUN or DRAIN)
//   clr_i          clear the half-period counter (run start)
//   ratio_i        half-period minus one, in clk_in cycles
//   clk_div_o      registered divided clock
//   rise_o         this cycle's edge takes clk_div 0->1 (combinational)
//   fall_o         this cycle's edge takes clk_div 1->0 (combinational)
module div_core
    import div_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] ratio_i,
    output logic             clk_div_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             hit;

    // >= rather than == so a counter value above the ratio can never stall.
    assign hit    = en_i && (cnt_q >= ratio_i);
    assign rise_o = hit && !clk_q;
    assign fall_o = hit &&  clk_q;

    assign clk_div_o = clk_q;

    always_comb begin
        cnt_d = cnt_q;
        clk_d = clk_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (hit) begin
                cnt_d = '0;
                clk_d = ~clk_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: programmable clock divider with burst mode and a one-deep
// configuration buffer.
// Ports:
//   clk_in, rst_n  clock / asynchronous active-low reset
//   cfg_valid/cfg_ready  configuration handshake (cfg_div, cfg_burst)
//   cfg_div        half-period minus one
//   cfg_burst      rising edges per burst, 0 = continuous
//   start, stop    single-cycle run / halt requests (stop has priority)
//   clk_div        divided clock
//   tick           pulse in the first cycle clk_div reads 1
//   busy           high in RUN and DRAIN
//   done           pulse when a burst completes
//
// state | meaning
// IDLE  | clk_div parked low, pending config applied immediately
// RUN   | dividing; burst count tracked when started in burst mode
// DRAIN | stop seen during high half; finish it, fall, return to IDLE
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               clk_div,
    output logic               tick,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   div_act_q, div_act_d;
    logic [BURST_W-1:0] burst_act_q, burst_act_d;
    logic               pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]   pend_div_q, pend_div_d;
    logic [BURST_W-1:0] pend_burst_q, pend_burst_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               bmode_q, bmode_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;

    logic core_en, core_clr, rise, fall;
    logic accept, apply;

    div_core #(.CNT_W(CNT_W)) u_core (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en_i      (core_en),
        .clr_i     (core_clr),
        .ratio_i   (div_act_q),
        .clk_div_o (clk_div),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    assign cfg_ready = !pend_valid_q;
    assign accept    = cfg_valid && !pend_valid_q;
    // While running, a new ratio is only taken at a falling edge so both
    // halves of every period are whole.
    assign apply     = pend_valid_q && ((state_q == ST_IDLE) || fall);

    assign busy = (state_q != ST_IDLE);
    assign tick = tick_q;
    assign done = done_q;

    always_comb begin
        state_d      = state_q;
        div_act_d    = div_act_q;
        burst_act_d  = burst_act_q;
        pend_valid_d = pend_valid_q;
        pend_div_d   = pend_div_q;
        pend_burst_d = pend_burst_q;
        rem_d        = rem_q;
        bmode_d      = bmode_q;
        tick_d       = 1'b0;
        done_d       = 1'b0;
        core_en      = 1'b0;
        core_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    core_clr = 1'b1;
                    rem_d    = burst_act_q;
                    // Mode latched here so a mid-run burst change waits for
                    // the next start.
                    bmode_d  = (burst_act_q != '0);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Stopping in the low half must not let a rising edge slip out.
                core_en = !(stop && !clk_div);
                if (stop) begin
                    if (!clk_div || fall) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (fall && bmode_q && (rem_q == '0)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                core_en = 1'b1;
                if (fall) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rise) begin
            tick_d = 1'b1;
            if (bmode_q) begin
                rem_d = rem_q - BURST_W'(1);
            end
        end

        if (apply) begin
            div_act_d    = pend_div_q;
            burst_act_d  = pend_burst_q;
            pend_valid_d = 1'b0;
        end
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_div_d   = cfg_div;
            pend_burst_d = cfg_burst;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_act_q    <= CNT_W'(DIV_RST);
            burst_act_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_div_q   <= '0;
            pend_burst_q <= '0;
            rem_q        <= '0;
            bmode_q      <= 1'b0;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_act_q    <= div_act_d;
            burst_act_q  <= burst_act_d;
            pend_valid_q <= pend_valid_d;
            pend_div_q   <= pend_div_d;
            pend_burst_q <= pend_burst_d;
            rem_q        <= rem_d;
            bmode_q      <= bmode_d;
            tick_q       <= tick_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl.
module tb_div_ctrl;

    localparam int CW = 16;
    localparam int BW = 16;

    logic          clk_in    = 1'b0;
    logic          rst_n     = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [CW-1:0] cfg_div   = '0;
    logic [BW-1:0] cfg_burst = '0;
    logic          start     = 1'b0;
    logic          stop      = 1'b0;
    logic          cfg_ready, clk_div, tick, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_cnt = 0;
    int done_cnt = 0;

    div_ctrl #(.CNT_W(CW), .BURST_W(BW), .DIV_RST(3)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_burst (cfg_burst),
        .start     (start),
        .stop      (stop),
        .clk_div   (clk_div),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (tick === 1'b1) tick_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        rst_n     = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    // Offer a config from IDLE and wait until it has been applied.
    task automatic load_cfg(input int d, input int b);
        int g;
        g = 0;
        cfg_div   = CW'(d);
        cfg_burst = BW'(b);
        cfg_valid = 1'b1;
        while (!cfg_ready && g < 100) begin
            step();
            g++;
        end
        if (g >= 100) check("cfg_ready_timeout", 0, 1);
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_tick(output int e);
        e = 0;
        do begin
            step();
            e++;
        end while (tick !== 1'b1 && e < 200);
    endtask

    // Length of the clk_div run at value v, counting the current sample.
    task automatic run_len(input logic v, output int n);
        n = 0;
        while (clk_div === v && n < 200) begin
            n++;
            step();
        end
    endtask

    typedef struct {
        int div;
        int burst;
        int first;
        int high;
        int period;
        int ticks;
        int done_at;
    } vec_t;

    vec_t vecs[8];
    logic tr_clk [1:64];
    logic tr_tick[1:64];
    logic tr_done[1:64];
    logic tr_busy[1:64];

    int e, h, l, t0, d0, rdy_bad, g;
    int first, second, nt, nd, dat;
    int d, b, s, p, burst_end, stop_end, idle_at, mism, use_stop, done_exp;
    int e_clk, e_tick, e_busy, e_done, act;
    string nm;

    initial begin
        vecs[0] = '{3, 0, 4, 4, 8, 8, 0};
        vecs[1] = '{0, 0, 1, 1, 2, 32, 0};
        vecs[2] = '{2, 0, 3, 3, 6, 11, 0};
        vecs[3] = '{7, 0, 8, 8, 16, 4, 0};
        vecs[4] = '{1, 3, 2, 2, 4, 3, 12};
        vecs[5] = '{5, 2, 6, 6, 12, 2, 24};
        vecs[6] = '{0, 1, 1, 1, 0, 1, 2};
        vecs[7] = '{0, 5, 1, 1, 2, 5, 10};

        #2;
        do_reset();

        // Reset state, then default ratio (3) without any config.
        check("rst_clk_div",   int'(clk_div),   0);
        check("rst_tick",      int'(tick),      0);
        check("rst_done",      int'(done),      0);
        check("rst_busy",      int'(busy),      0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        pulse_start();
        wait_tick(e);
        check("rst_default_first_tick", e, 4);
        check("rst_default_busy", int'(busy), 1);

        // Table vectors: trace 64 cycles after start and analyse.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            load_cfg(vecs[v].div, vecs[v].burst);
            pulse_start();
            for (int i = 1; i <= 64; i++) begin
                step();
                tr_clk[i]  = clk_div;
                tr_tick[i] = tick;
                tr_done[i] = done;
                tr_busy[i] = busy;
            end
            first = -1; second = -1; nt = 0; nd = 0; dat = 0; h = 0;
            for (int i = 1; i <= 64; i++) begin
                if (tr_tick[i] === 1'b1) begin
                    nt++;
                    if (first < 0) first = i;
                    else if (second < 0) second = i;
                end
                if (tr_done[i] === 1'b1) begin
                    nd++;
                    if (dat == 0) dat = i;
                end
            end
            if (first > 0) begin
                for (int j = first; j <= 64 && tr_clk[j] === 1'b1; j++) h++;
            end
            check($sformatf("vec%0d_first_tick", v), first, vecs[v].first);
            check($sformatf("vec%0d_high_len", v), h, vecs[v].high);
            check($sformatf("vec%0d_tick_count", v), nt, vecs[v].ticks);
            check($sformatf("vec%0d_done_at", v), dat, vecs[v].done_at);
            check($sformatf("vec%0d_done_count", v), nd, (vecs[v].done_at != 0) ? 1 : 0);
            check($sformatf("vec%0d_busy_early", v), int'(tr_busy[1]), 1);
            if (vecs[v].period != 0)
                check($sformatf("vec%0d_period", v), second - first, vecs[v].period);
            if (vecs[v].done_at != 0) begin
                check($sformatf("vec%0d_clk_at_done", v), int'(tr_clk[vecs[v].done_at]), 0);
                check($sformatf("vec%0d_busy_at_done", v), int'(tr_busy[vecs[v].done_at]), 0);
            end
        end

        // Ratio change offered mid-high: held until the fall, then 6/6.
        do_reset();
        load_cfg(2, 0);
        pulse_start();
        wait_tick(e);
        cfg_div   = CW'(5);
        cfg_burst = BW'(0);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        rdy_bad = 0; g = 0;
        while (clk_div === 1'b1 && g < 50) begin
            if (cfg_ready !== 1'b0) rdy_bad++;
            step();
            g++;
        end
        check("chg_ready_low_while_pending", rdy_bad, 0);
        check("chg_ready_after_fall", int'(cfg_ready), 1);
        run_len(1'b0, l);
        check("chg_low_len", l, 6);
        run_len(1'b1, h);
        check("chg_high_len", h, 6);

        // Stop during high half: half completes (5 cycles), no done.
        do_reset();
        load_cfg(4, 0);
        pulse_start();
        wait_tick(e);
        d0 = done_cnt;
        step();
        h = 2;
        stop = 1'b1;
        step();
        stop = 1'b0;
        g = 0;
        while (clk_div === 1'b1 && g < 50) begin
            h++;
            step();
            g++;
        end
        check("stop_hi_high_len", h, 5);
        check("stop_hi_busy_after", int'(busy), 0);
        t0 = tick_cnt;
        repeat (15) step();
        check("stop_hi_no_more_ticks", tick_cnt - t0, 0);
        check("stop_hi_no_done", done_cnt - d0, 0);

        // Stop during low half: IDLE on the next cycle.
        pulse_start();
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_lo_busy", int'(busy), 0);
        check("stop_lo_clk", int'(clk_div), 0);
        t0 = tick_cnt;
        repeat (15) step();
        check("stop_lo_no_ticks", tick_cnt - t0, 0);

        // start+stop together in IDLE does nothing; start in RUN is ignored.
        do_reset();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", int'(busy), 0);
        t0 = tick_cnt;
        repeat (10) step();
        check("startstop_no_ticks", tick_cnt - t0, 0);
        pulse_start();
        wait_tick(e);
        start = 1'b1;
        step();
        start = 1'b0;
        run_len(1'b1, h);
        check("start_in_run_high_rest", h, 3);
        run_len(1'b0, l);
        check("start_in_run_low_len", l, 4);

        // Asynchronous reset mid-high discards the pending config.
        do_reset();
        load_cfg(5, 0);
        pulse_start();
        wait_tick(e);
        step();
        cfg_div   = CW'(7);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("arst_pre_clk_high", int'(clk_div), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_clk_low_async", int'(clk_div), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_cfg_ready", int'(cfg_ready), 1);
        #2;
        rst_n = 1'b1;
        step();
        check("arst_cfg_ready_after", int'(cfg_ready), 1);
        pulse_start();
        wait_tick(e);
        check("arst_default_ratio_tick", e, 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (10) step();

        // Randomised runs against a closed-form timing model.
        for (int t = 0; t < 30; t++) begin
            d = $urandom_range(0, 5);
            b = $urandom_range(0, 4);
            s = $urandom_range(1, 50);
            use_stop = (b == 0 || $urandom_range(0, 1) == 1) ? 1 : 0;
            p = d + 1;
            burst_end = (b != 0) ? 2 * b * p : 1 << 30;
            stop_end  = 1 << 30;
            if (use_stop != 0 && (s - 1) < burst_end)
                stop_end = ((((s - 1) / p) % 2) == 0) ? s : (((s - 1) / p) + 1) * p;
            idle_at  = (burst_end < stop_end) ? burst_end : stop_end;
            done_exp = (burst_end < stop_end) ? 1 : 0;
            load_cfg(d, b);
            pulse_start();
            mism = 0;
            nm = "";
            for (int i = 1; i <= idle_at + 3; i++) begin
                stop = (use_stop != 0 && i == s);
                step();
                act    = (i < idle_at) ? 1 : 0;
                e_clk  = (act != 0) ? ((i / p) % 2) : 0;
                e_tick = (act != 0 && (i % p) == 0 && ((i / p) % 2) == 1) ? 1 : 0;
                e_busy = act;
                e_done = (done_exp != 0 && i == idle_at) ? 1 : 0;
                if (int'(clk_div) !== e_clk || int'(tick) !== e_tick ||
                    int'(busy) !== e_busy || int'(done) !== e_done) begin
                    if (mism == 0)
                        nm = $sformatf(" first@%0d clk=%0d/%0d tick=%0d/%0d busy=%0d/%0d done=%0d/%0d",
                                       i, clk_div, e_clk, tick, e_tick, busy, e_busy, done, e_done);
                    mism++;
                end
            end
            stop = 1'b0;
            check($sformatf("rand_t%0d_d%0d_b%0d_s%0d_stop%0d%s", t, d, b, s, use_stop, nm), mism, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
